uart_tx: RTL and testbench

Byte-serial UART transmitter, the transmit-side counterpart of the team's `uart_rx`. It accepts one byte per valid/ready handshake and serialises it onto a single line as a frame: start bit, 8 data bits LSB first, optional even-parity bit, stop bit. The bit period is derived from the system clock by an internal baud counter. It sits between the host-side byte producer and the board TX pin.

---
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to include the parity bit (8E1); default build is 8N1.
module uart_tx #(
    parameter int BAUD_RATE      = 115_200,
    parameter int EXTERNAL_CLOCK = 50_000_000
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx
);

    localparam int CLKS_PER_BIT = EXTERNAL_CLOCK / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: EXTERNAL_CLOCK / BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_done = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (data_valid && ready_q) begin
                    state_d  = START;
                    cnt_d    = '0;
                    idx_d    = '0;
                    shift_d  = data_in;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the pins change on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            tx_q     <= tx_d;
            ready_q  <= ready_d;
        end
    end

    assign tx    = tx_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit; frame shape follows UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NBITS  = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NBITS  = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       data_valid;
    logic [7:0] data_in;
    logic       ready;
    logic       tx;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx #(
        .BAUD_RATE     (2),
        .EXTERNAL_CLOCK(8)
    ) dut (
        .clk       (clk),
        .sync_reset(sync_reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .ready     (ready),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR_EN && b == 9) return p;
        return 1'b1;
    endfunction

    // Called just after the accepting edge; checks every cycle of the frame and the idle edge after it.
    task automatic run_frame(input logic [7:0] d, input logic p, input string tag, input bit poke);
        for (int i = 0; i < FRAME; i++) begin
            check({tag, " tx"}, tx, exp_bit(d, p, i / CPB));
            check({tag, " ready"}, ready, 0);
            if (poke && i == FRAME / 2) begin
                data_valid = 1'b1;
                data_in    = ~d;
            end
            if (poke && i == FRAME / 2 + 1) data_valid = 1'b0;
            tick();
        end
        check({tag, " end tx"}, tx, 1);
        check({tag, " end ready"}, ready, 1);
    endtask

    task automatic send(input vec_t v, input string tag, input bit poke);
        data_in    = v.data;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = ~v.data;
        run_frame(v.data, v.par, tag, poke);
    endtask

    // Line-side receiver model: mid-bit sampling, pushes each well-framed byte.
    logic [7:0] rx_q[$];
    int         rx_err = 0;

    initial begin
        logic [7:0] b;
        bit         ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                if (PAR_EN) repeat (CPB) @(negedge clk);
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (ok) rx_q.push_back(b);
                else rx_err++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hBD, 1'b0};
        vecs[1] = '{8'h01, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h7E, 1'b0};
        vecs[6] = '{8'h3C, 1'b0};
        vecs[7] = '{8'hC6, 1'b0};

        // Reset held three cycles with data_valid high: reset must win.
        sync_reset = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hBD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset tx", tx, 1);
            check("reset ready", ready, 1);
        end
        sync_reset = 1'b0;
        data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post reset tx", tx, 1);
            check("post reset ready", ready, 1);
        end

        foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // Back-to-back with data_valid held: one idle cycle between stop and next start.
        rx_q.delete();
        data_in    = 8'h55;
        data_valid = 1'b1;
        tick();
        data_in = 8'hA3;
        run_frame(8'h55, 1'b0, "b2b first", 1'b0);
        tick();
        data_valid = 1'b0;
        run_frame(8'hA3, 1'b0, "b2b second", 1'b0);
        repeat (2) tick();
        check("b2b rx count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b rx byte0", rx_q[0], 8'h55);
            check("b2b rx byte1", rx_q[1], 8'hA3);
        end
        check("rx framing errors", rx_err, 0);

        // Reset in the middle of DATA, then a clean frame.
        data_in    = 8'hC6;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("pre-reset tx", tx, exp_bit(8'hC6, 1'b0, i / CPB));
            tick();
        end
        sync_reset = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        check("midframe reset tx", tx, 1);
        check("midframe reset ready", ready, 1);
        sync_reset = 1'b0;
        data_valid = 1'b0;
        tick();
        check("after reset tx", tx, 1);
        check("after reset ready", ready, 1);
        send('{8'h5A, 1'b0}, "recovery", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
